clk_div_ctrl: RTL and testbench

CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

---
 rtl/clk_div_pkg.sv | 15 +
 rtl/clk_div_core.sv | 51 +++++
 rtl/clk_div_ctrl.sv | 95 +++++++++
 tb/tb_clk_div_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared definitions for the clock divider controller.
//   CNT_W_DEF : default width of the half-period divide field
//   state_t   : controller FSM state encoding (IDLE/RUN/PEND/STOP)
package clk_div_pkg;

    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2,
        STOP = 2'd3
    } state_t;

endpackage

// File: rtl/clk_div_core.sv
// Counter/toggle datapath of the clock divider.
//   clk_in  : system clock (rising edge)
//   reset   : asynchronous, active-high
//   load    : capture div as the active half-period value and clear the counter
//   div     : half-period length minus 1 to capture on load
//   run     : 1 = count and toggle, 0 = hold counter at 0 and clk_out low
//   clk_out : registered divided clock
//   toggle  : clk_out will change on the next rising edge
module clk_div_core
    import clk_div_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] div,
    input  logic             run,
    output logic             clk_out,
    output logic             toggle
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div_r;

    // Counter only ever counts up to div_r, and div_r changes only together
    // with a counter clear, so the counter can never pass div_r or wrap.
    assign toggle = run && (cnt == div_r);

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            div_r   <= '0;
            clk_out <= 1'b0;
        end else begin
            if (load)
                div_r <= div;

            if (load || !run || toggle)
                cnt <= '0;
            else
                cnt <= cnt + CNT_W'(1);

            if (!run)
                clk_out <= 1'b0;
            else if (toggle)
                clk_out <= ~clk_out;
        end
    end

endmodule

// File: rtl/clk_div_ctrl.sv
// Glitch-free programmable clock divider controller.
//   clk_in    : system clock (rising edge)
//   reset     : asynchronous, active-high
//   cfg_valid : configuration request valid
//   cfg_ready : configuration can be accepted (IDLE or RUN)
//   cfg_en    : 1 = run at cfg_div, 0 = stop request
//   cfg_div   : half-period length minus 1, in clk_in cycles
//   clk_out   : registered divided clock, period 2*(div+1)
//   tick_rise : one-cycle pulse in the cycle clk_out becomes 1
//   tick_fall : one-cycle pulse in the cycle clk_out becomes 0
//   state     : current FSM state
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic             cfg_en,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             clk_out,
    output logic             tick_rise,
    output logic             tick_fall,
    output logic [1:0]       state
);

    state_t           st, st_nxt;
    logic [CNT_W-1:0] pend;
    logic [CNT_W-1:0] div_sel;
    logic             xfer;
    logic             load;
    logic             run;
    logic             toggle;
    logic             fall_hit;

    assign cfg_ready = (st == IDLE) || (st == RUN);
    assign xfer      = cfg_valid && cfg_ready;
    assign run       = (st != IDLE);
    // Rate changes and stops only take effect at a falling edge, so the
    // low half after the edge is the first one timed by the new value.
    assign fall_hit  = toggle && clk_out;
    assign div_sel   = (st == IDLE) ? cfg_div : pend;
    assign state     = st;

    always_comb begin
        st_nxt = st;
        load   = 1'b0;
        case (st)
            IDLE: if (xfer && cfg_en) begin
                load   = 1'b1;
                st_nxt = RUN;
            end
            RUN:  if (xfer)
                st_nxt = cfg_en ? PEND : STOP;
            PEND: if (fall_hit) begin
                load   = 1'b1;
                st_nxt = RUN;
            end
            STOP: if (fall_hit)
                st_nxt = IDLE;
            default: st_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            st        <= IDLE;
            pend      <= '0;
            tick_rise <= 1'b0;
            tick_fall <= 1'b0;
        end else begin
            st <= st_nxt;
            if (st == RUN && xfer && cfg_en)
                pend <= cfg_div;
            // Ticks are registered alongside clk_out so they line up with
            // the cycle it changes; the last fall of a stop lands in the
            // first IDLE cycle, no tick originates from IDLE.
            tick_rise <= toggle && !clk_out;
            tick_fall <= toggle && clk_out;
        end
    end

    clk_div_core #(.CNT_W(CNT_W)) u_core (
        .clk_in  (clk_in),
        .reset   (reset),
        .load    (load),
        .div     (div_sel),
        .run     (run),
        .clk_out (clk_out),
        .toggle  (toggle)
    );

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl. Expected tick events (kind + cycle)
// are queued when a configuration is driven and popped by a monitor as the
// DUT produces them; state/handshake values are checked inline.
module tb_clk_div_ctrl;

    localparam int CNT_W = 8;

    logic             clk_in = 1'b0;
    logic             reset;
    logic             cfg_valid;
    logic             cfg_ready;
    logic             cfg_en;
    logic [CNT_W-1:0] cfg_div;
    logic             clk_out;
    logic             tick_rise;
    logic             tick_fall;
    logic [1:0]       state;

    typedef struct {
        bit rise;
        int cyc;
    } tk_t;

    tk_t sb[$];
    int  n_chk = 0;
    int  n_err = 0;
    int  cyc   = 0;
    logic prev_clk = 1'b0;

    clk_div_ctrl #(.CNT_W(CNT_W)) dut (
        .clk_in    (clk_in),
        .reset     (reset),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_en    (cfg_en),
        .cfg_div   (cfg_div),
        .clk_out   (clk_out),
        .tick_rise (tick_rise),
        .tick_fall (tick_fall),
        .state     (state)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push_tk(input bit r, input int c);
        tk_t e;
        e.rise = r;
        e.cyc  = c;
        sb.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk_in);
    endtask

    // Called at a negedge; the transfer happens at the next rising edge,
    // whose cycle number is returned. Returns at the following negedge.
    task automatic xfer(input logic en, input logic [CNT_W-1:0] d, output int t);
        cfg_valid = 1'b1;
        cfg_en    = en;
        cfg_div   = d;
        t         = cyc + 1;
        @(negedge clk_in);
        cfg_valid = 1'b0;
    endtask

    // Tick monitor: every tick must match the head of the scoreboard, and
    // ticks must coincide exactly with clk_out edges.
    always @(negedge clk_in) begin
        if (reset) begin
            prev_clk <= 1'b0;
        end else begin
            chk("rise_vs_edge", tick_rise, clk_out && !prev_clk);
            chk("fall_vs_edge", tick_fall, !clk_out && prev_clk);
            if (tick_rise || tick_fall) begin
                chk("tick_both", tick_rise && tick_fall, 0);
                if (sb.size() == 0) begin
                    chk("unexp_tick", sb.size(), 1);
                end else begin
                    tk_t e;
                    e = sb.pop_front();
                    chk("tick_cyc", cyc, e.cyc);
                    chk("tick_kind", tick_rise, e.rise);
                end
            end
            prev_clk <= clk_out;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout cycle=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int t, t2;
        reset     = 1'b1;
        cfg_valid = 1'b0;
        cfg_en    = 1'b0;
        cfg_div   = '0;
        repeat (2) @(negedge clk_in);
        chk("rst_state", state, 0);
        chk("rst_clk", clk_out, 0);
        chk("rst_rise", tick_rise, 0);
        chk("rst_fall", tick_fall, 0);
        #2 reset = 1'b0;
        @(negedge clk_in);
        chk("rst_ready", cfg_ready, 1);

        // Enable with en=0 in IDLE is ignored.
        xfer(1'b0, 8'd5, t);
        chk("idle_en0_state", state, 0);

        // div=3: 4 low / 4 high, then rate change to div=1 while high.
        xfer(1'b1, 8'd3, t);
        chk("a_state_run", state, 1);
        chk("a_clk_low", clk_out, 0);
        push_tk(1'b1, t + 4);
        push_tk(1'b0, t + 8);
        push_tk(1'b1, t + 12);
        push_tk(1'b0, t + 16);
        wait_cyc(t + 3);
        chk("a_low_end", clk_out, 0);
        wait_cyc(t + 7);
        chk("a_high_end", clk_out, 1);
        wait_cyc(t + 12);
        chk("a_high2", clk_out, 1);
        cfg_valid = 1'b1;
        cfg_en    = 1'b1;
        cfg_div   = 8'd1;
        @(negedge clk_in);
        chk("a_pend", state, 2);
        chk("a_pend_ready", cfg_ready, 0);
        // Held request with a different div must not be taken while busy.
        cfg_div = 8'd0;
        repeat (3) @(negedge clk_in);
        cfg_valid = 1'b0;
        chk("a_back_run", state, 1);
        chk("a_ready_again", cfg_ready, 1);
        push_tk(1'b1, t + 18);
        push_tk(1'b0, t + 20);
        push_tk(1'b1, t + 22);
        push_tk(1'b0, t + 24);
        wait_cyc(t + 22);
        xfer(1'b0, 8'd0, t2);
        chk("a_stop", state, 3);
        wait_cyc(t + 24);
        chk("a_idle", state, 0);
        chk("a_idle_clk", clk_out, 0);
        repeat (8) @(negedge clk_in);
        chk("a_sb_empty", sb.size(), 0);

        // div=2, stop just after tick_rise.
        xfer(1'b1, 8'd2, t);
        push_tk(1'b1, t + 3);
        push_tk(1'b0, t + 6);
        wait_cyc(t + 3);
        chk("b_rise_now", tick_rise, 1);
        xfer(1'b0, 8'd0, t2);
        chk("b_stop", state, 3);
        chk("b_stop_ready", cfg_ready, 0);
        chk("b_still_high", clk_out, 1);
        wait_cyc(t + 6);
        chk("b_idle", state, 0);
        chk("b_idle_clk", clk_out, 0);
        repeat (10) @(negedge clk_in);
        chk("b_quiet_clk", clk_out, 0);
        chk("b_sb_empty", sb.size(), 0);

        // div=0: divide-by-2, ticks alternate every cycle.
        xfer(1'b1, 8'd0, t);
        for (int i = 1; i <= 10; i++)
            push_tk((i % 2) == 1, t + i);
        wait_cyc(t + 8);
        xfer(1'b0, 8'd0, t2);
        wait_cyc(t + 10);
        chk("c_idle", state, 0);
        repeat (4) @(negedge clk_in);
        chk("c_sb_empty", sb.size(), 0);

        // Reset in PEND during the high half.
        xfer(1'b1, 8'd3, t);
        push_tk(1'b1, t + 4);
        wait_cyc(t + 4);
        xfer(1'b1, 8'd1, t2);
        chk("d_pend", state, 2);
        @(posedge clk_in);
        #1;
        chk("d_pre_rst_clk", clk_out, 1);
        #1 reset = 1'b1;
        #1;
        chk("d_rst_clk", clk_out, 0);
        chk("d_rst_state", state, 0);
        chk("d_rst_rise", tick_rise, 0);
        chk("d_rst_fall", tick_fall, 0);
        @(negedge clk_in);
        #2 reset = 1'b0;
        @(negedge clk_in);
        chk("d_ready", cfg_ready, 1);
        chk("d_sb_empty0", sb.size(), 0);
        xfer(1'b1, 8'd2, t);
        push_tk(1'b1, t + 3);
        push_tk(1'b0, t + 6);
        wait_cyc(t + 3);
        xfer(1'b0, 8'd0, t2);
        wait_cyc(t + 6);
        chk("d_idle", state, 0);
        repeat (4) @(negedge clk_in);
        chk("d_sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
